// File: rtl/rx_tlp_dispatcher_pkg.sv
// Shared definitions for the RX TLP dispatcher: default sizing, the
// one-hot FSM encoding and a small unsigned min helper.
package rx_tlp_dispatcher_pkg;

  localparam int DEF_BUF_AW         = 15;
  localparam int DEF_TLP_QW_LOG2    = 4;
  localparam int DEF_TLP_QW         = 1 << DEF_TLP_QW_LOG2;
  localparam int DEF_PAGE_QW_LOG2   = 18;
  localparam int DEF_PAGE_QW        = 1 << DEF_PAGE_QW_LOG2;
  localparam int DEF_HDR_QW         = 16;
  localparam int DEF_TIMEOUT_CYCLES = 65536;
  localparam int DEF_MAX_BURST      = 8;

  // One-hot dispatcher states
  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_CALC     = 6'b000010,
    ST_REQ      = 6'b000100,
    ST_UPD      = 6'b001000,
    ST_PAGE_REQ = 6'b010000,
    ST_PAGE_UPD = 6'b100000
  } state_t;

  function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/rx_tlp_timeout.sv
// Idle timeout generator with a sticky flush request. The counter runs
// only while 'run' is high; a flush pulse is remembered until the
// dispatcher is back in IDLE ('consume') and acts as an immediate timeout.
module rx_tlp_timeout
  import rx_tlp_dispatcher_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic flush_req,
  input  logic consume,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_flush;
  logic             w_expired;

  assign w_expired = run && (r_cnt == CNT_LAST);
  assign timeout   = w_expired || r_flush;

  // Idle counter: clears when not running, wraps after firing once
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!run || w_expired) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Sticky flush: a new pulse wins over consumption in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush <= 1'b0;
    end else begin
      r_flush <= flush_req | (r_flush & ~consume);
    end
  end

endmodule

// File: rtl/rx_tlp_dispatcher.sv
// RX TLP dispatcher: turns committed ring-buffer qwords into DMA TLP
// requests of 1..TLP_QW qwords, never crossing a host huge page, and
// requests a page change when the page fills or idles while dirty.
module rx_tlp_dispatcher
  import rx_tlp_dispatcher_pkg::*;
#(
  parameter int BUF_AW         = DEF_BUF_AW,
  parameter int TLP_QW_LOG2    = $clog2(DEF_TLP_QW),
  parameter int PAGE_QW_LOG2   = $clog2(DEF_PAGE_QW),
  parameter int HDR_QW         = DEF_HDR_QW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_BURST      = DEF_MAX_BURST
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [BUF_AW-1:0]       commited_wr_address,
  input  logic                    flush_req,
  output logic                    trigger_tlp,
  input  logic                    trigger_tlp_ack,
  output logic [TLP_QW_LOG2:0]    qwords_to_send,
  output logic [PAGE_QW_LOG2:0]   page_qword_offset,
  output logic                    change_huge_page,
  input  logic                    change_huge_page_ack,
  output logic [BUF_AW-1:0]       commited_rd_address,
  output logic                    busy
);

  localparam int TLP_QW  = 1 << TLP_QW_LOG2;
  localparam int PAGE_QW = 1 << PAGE_QW_LOG2;
  localparam int PG_W    = PAGE_QW_LOG2 + 1;
  localparam int SZ_W    = TLP_QW_LOG2 + 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  localparam logic [PG_W-1:0]    PAGE_QW_P = PG_W'(PAGE_QW);
  localparam logic [PG_W-1:0]    HDR_QW_P  = PG_W'(HDR_QW);
  localparam logic [BUF_AW-1:0]  TLP_QW_B  = BUF_AW'(TLP_QW);

  state_t              r_state;
  logic [BUF_AW-1:0]   r_pending;
  logic [BUF_AW-1:0]   r_rd;
  logic [PG_W-1:0]     r_page_cnt;
  logic [PG_W-1:0]     r_offset;
  logic [SZ_W-1:0]     r_qwords;
  logic [BURST_W-1:0]  r_burst;
  logic                r_dirty;
  logic                r_trigger;
  logic                r_change;

  logic                w_idle;
  logic                w_run;
  logic                w_timeout;
  logic                w_pending_nz;
  logic                w_pending_ge_tlp;
  logic [PG_W-1:0]     w_page_space;
  logic [SZ_W-1:0]     w_calc_size;
  logic [BUF_AW-1:0]   w_rd_next;
  logic [BUF_AW-1:0]   w_pending_after;
  logic [PG_W-1:0]     w_page_cnt_next;
  logic [BURST_W-1:0]  w_burst_next;

  assign w_idle           = (r_state == ST_IDLE);
  assign w_pending_nz     = (r_pending != '0);
  assign w_pending_ge_tlp = (r_pending >= TLP_QW_B);
  assign w_run            = w_idle && (w_pending_nz || r_dirty);
  assign w_page_space     = PAGE_QW_P - r_page_cnt;
  assign w_calc_size      = SZ_W'(min_u32(min_u32(32'(TLP_QW), 32'(r_pending)), 32'(w_page_space)));
  assign w_rd_next        = r_rd + BUF_AW'(r_qwords);
  assign w_pending_after  = commited_wr_address - w_rd_next;
  assign w_page_cnt_next  = r_page_cnt + PG_W'(r_qwords);
  assign w_burst_next     = r_burst + BURST_W'(1);

  assign trigger_tlp         = r_trigger;
  assign change_huge_page    = r_change;
  assign qwords_to_send      = r_qwords;
  assign page_qword_offset   = r_offset;
  assign commited_rd_address = r_rd;
  assign busy                = !w_idle;

  rx_tlp_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .run      (w_run),
    .flush_req(flush_req),
    .consume  (w_idle),
    .timeout  (w_timeout)
  );

  // Pending qwords; in UPD take the post-update value so CALC never sees a stale count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else if (r_state == ST_UPD) begin
      r_pending <= w_pending_after;
    end else begin
      r_pending <= commited_wr_address - r_rd;
    end
  end

  // Dispatcher FSM with registered request outputs and pointer bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_trigger  <= 1'b0;
      r_change   <= 1'b0;
      r_qwords   <= '0;
      r_offset   <= HDR_QW_P;
      r_page_cnt <= HDR_QW_P;
      r_rd       <= '0;
      r_dirty    <= 1'b0;
      r_burst    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((w_page_space == '0) && (w_pending_nz || r_dirty)) begin
            r_change <= 1'b1;
            r_state  <= ST_PAGE_REQ;
          end else if (w_pending_ge_tlp || (w_pending_nz && w_timeout)) begin
            r_burst <= '0;
            r_state <= ST_CALC;
          end else if (r_dirty && w_timeout) begin
            r_change <= 1'b1;
            r_state  <= ST_PAGE_REQ;
          end
        end
        ST_CALC: begin
          if (w_calc_size == '0) begin
            r_change <= 1'b1;
            r_state  <= ST_PAGE_REQ;
          end else begin
            r_qwords  <= w_calc_size;
            r_offset  <= r_page_cnt;
            r_trigger <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (trigger_tlp_ack) begin
            r_trigger <= 1'b0;
            r_state   <= ST_UPD;
          end
        end
        ST_UPD: begin
          r_rd       <= w_rd_next;
          r_page_cnt <= w_page_cnt_next;
          r_dirty    <= 1'b1;
          r_burst    <= w_burst_next;
          if (w_page_cnt_next == PAGE_QW_P) begin
            r_change <= 1'b1;
            r_state  <= ST_PAGE_REQ;
          end else if ((w_burst_next < BURST_W'(MAX_BURST)) && (w_pending_after >= TLP_QW_B)) begin
            r_state <= ST_CALC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PAGE_REQ: begin
          if (change_huge_page_ack) begin
            r_change   <= 1'b0;
            r_page_cnt <= HDR_QW_P;
            r_dirty    <= 1'b0;
            r_state    <= ST_PAGE_UPD;
          end
        end
        ST_PAGE_UPD: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_trigger <= 1'b0;
          r_change  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
